sprite_rom_arbiter: RTL and testbench
=====================================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM between NREQ sprite-fetch requesters: bird, pipes, number digits, logo/medal overlays.
- Round-robin arbitration, at most one ROM read per cycle.
- Returns each read's data tagged one-hot to the requester that issued it, after a fixed ROM latency.
- Sits between the per-sprite pixel generators and the ROM; frame_start comes from the display timing (same pulse that feeds the game logic's new_frame).

Parameters:
- NREQ, 4, number of requesters (2..8).
- AW, 16, ROM address width.
- DW, 12, ROM data width (RGB444 pixel).
- ROM_LAT, 2, cycles from address presented to rom_data valid (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- frame_start  in  1  one-cycle pulse at frame boundary.
- req  in  NREQ  per-requester read request, level; held until granted.
- req_addr  in  NREQ*AW  packed addresses; slice i = bits [i*AW +: AW]; must be stable while req[i]=1.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the accepted request.
- rom_en  out  1  ROM read enable, combinational (= |gnt).
- rom_addr  out  AW  address of the granted requester; 0 when no grant.
- rom_data  in  DW  ROM output, valid ROM_LAT cycles after rom_en.
- rd_valid  out  NREQ  one-hot, registered; marks the owner of rd_data this cycle.
- rd_data  out  DW  registered copy of rom_data.
- overrun  out  1  sticky flag: some req pending when frame_start arrives.

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- Reset values: rd_valid=0, rd_data=0, overrun=0, rr pointer=0, tag pipeline all 0.
- Arbitration, per cycle:
  - Search req starting at index ptr, wrapping modulo NREQ; first set bit wins.
  - gnt has a single bit set for the winner; gnt=0 if req=0.
  - After a grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- Handshake:
  - Request accepted in cycle T when req[i]=1 and gnt[i]=1.
  - Requester may change address or drop req from T+1.
  - Back-to-back requests by the same requester are allowed; each costs one accepted cycle.
- Latency:
  - ROM samples rom_addr at the end of cycle T.
  - Tag pipeline of depth ROM_LAT carries gnt.
  - At T+ROM_LAT: rd_data <= rom_data and rd_valid <= tag. Registered outputs are visible one cycle after rom_data is valid.
- Throughput: one read per cycle sustained. With all requesters busy, each gets exactly 1 grant in every NREQ cycles.
- frame_start:
  - ptr <= 0, overriding any grant-driven update that cycle.
  - If req != 0 in that cycle, overrun <= 1.
  - A grant issued in the same cycle still completes normally.
  - overrun clears only on rst.
- rst asserted mid-operation: tag pipeline flushed. In-flight reads never produce rd_valid; gnt is forced 0 while rst=1.
- Widths:
  - ptr is ceil(log2(NREQ)) bits.
  - Wrap at NREQ-1 -> 0 is explicit (works for non-power-of-2 NREQ).
- No state machine beyond ptr and tags. Implementation: combinational rotate/priority-encode, plus ROM_LAT-deep shift register of NREQ-bit tags.

Optional Feature:
- Macro SPRITE_ARB_FIXED_PRIO_EN.
- Defined: requester 0 has absolute priority, then 1, 2, …; ptr is unused and held at 0; frame_start still drives overrun.
- Not defined: round-robin as above.
- Latency and tagging are identical in both modes.

Test Plan:
- Reset, then single req[2]=1, addr=0x0123 for one cycle, ROM_LAT=2:
  - gnt=4'b0100 and rom_addr=0x0123 in T.
  - rd_valid=4'b0100 with rd_data = ROM[0x0123] in cycle T+3.
- All req=4'b1111 held for 8 cycles from ptr=0: grants 0,1,2,3,0,1,2,3; rd_valid follows the same order, 3 cycles delayed.
- req=4'b1010 held: grants alternate 1,3,1,3. Then drop req[3]: requester 1 granted every cycle.
- frame_start while req[3]=1 ungranted (ptr=3 moving to 0): overrun=1 next cycle and stays 1; next grant search starts at 0.
- rst asserted 1 cycle after a grant: no rd_valid pulse ever appears for that read; all outputs 0 the cycle after rst.
- With SPRITE_ARB_FIXED_PRIO_EN and req=4'b1111 held: gnt=4'b0001 every cycle; requesters 1-3 never granted until req[0] drops.

Source files
------------

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM-side bus of the sprite ROM arbiter: per-requester request and
// address, grant, ROM address/data, and the tagged read return.
interface sprite_rom_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 12
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic               rom_en;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data;

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rom_en, rom_addr, rd_valid, rd_data
  );

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rom_en, rom_addr, rd_valid, rd_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin sharing of one synchronous sprite ROM among NREQ fetchers, with
// one-hot tagged read return. Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority.
module sprite_rom_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 16,
  parameter int DW      = 12,
  parameter int ROM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  sprite_rom_arbiter_if.slave bus,
  output logic                overrun
);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   win;
  logic            found;
  logic [NREQ-1:0] gnt_c;
  logic [NREQ-1:0] tag [ROM_LAT];

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_c = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[k]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
    if (rst) found = 1'b0;
    if (found) gnt_c[win] = 1'b1;
  end
`else
  localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

  logic [PW-1:0] ptr;
  logic [PW:0]   idx;

  // idx carries one extra bit so ptr+k can be folded back below NREQ
  // without relying on power-of-2 wrap.
  always_comb begin
    gnt_c = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && bus.req[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
    if (rst) found = 1'b0;
    if (found) gnt_c[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) ptr <= '0;
    else if (found)         ptr <= (win == LAST) ? '0 : win + 1'b1;
  end
`endif

  assign bus.gnt      = gnt_c;
  assign bus.rom_en   = found;
  assign bus.rom_addr = found ? bus.req_addr[int'(win)*AW +: AW] : '0;

  // Grant tags ride alongside the ROM pipeline so the returning data lands
  // on the requester that issued the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) tag[i] <= '0;
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      tag[0] <= gnt_c;
      for (int i = 1; i < ROM_LAT; i++) tag[i] <= tag[i-1];
      bus.rd_valid <= tag[ROM_LAT-1];
      bus.rd_data  <= bus.rom_data;
      if (frame_start && (|bus.req)) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed test-plan sequences plus
// randomized protocol-following traffic against a queue-based reference model.
module tb_sprite_rom_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 16;
  localparam int DW   = 12;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic overrun;

  sprite_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bus(bus), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
    return DW'((a * 16'd37) ^ (a >> 5) ^ 16'h00A5);
  endfunction

  // Synchronous ROM with LAT cycles from address to data.
  logic [AW-1:0] rpipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    rpipe[0] <= bus.rom_addr;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.rom_data = rom_fn(rpipe[LAT-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              due;
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   data;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit after_rst = 1'b0;
  logic exp_ovr = 1'b0;
  int m_ptr = 0;
  int last_w = -1;
  logic [AW-1:0] addr_q [NREQ];
  logic [NREQ-1:0] cur_req = '0;

  function automatic int model_pick(logic [NREQ-1:0] r);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.rd_valid !== e.oh || bus.rd_data !== e.data) begin
          errors++;
          $display("FAIL rd_return cycle %0d: got valid=%b data=%h expected valid=%b data=%h",
                   cyc, bus.rd_valid, bus.rd_data, e.oh, e.data);
        end
      end else if (bus.rd_valid !== '0) begin
        errors++;
        $display("FAIL rd_idle cycle %0d: got valid=%b expected valid=%b", cyc, bus.rd_valid, {NREQ{1'b0}});
      end
    end
  end

  task automatic step(input logic r, input logic fs, input logic [NREQ-1:0] rq);
    int w;
    logic [NREQ-1:0] eg;
    logic [AW-1:0] ea;
    exp_t keep[$];
    @(negedge clk);
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL overrun cycle %0d: got %b expected %b", cyc, overrun, exp_ovr);
    end
    if (after_rst) begin
      checks++;
      if (bus.rd_valid !== '0 || bus.rd_data !== '0) begin
        errors++;
        $display("FAIL post_reset cycle %0d: got valid=%b data=%h expected 0/0", cyc, bus.rd_valid, bus.rd_data);
      end
    end
    rst = r;
    frame_start = fs;
    bus.req = rq;
    for (int i = 0; i < NREQ; i++) bus.req_addr[i*AW +: AW] = addr_q[i];
    #1;
    w  = r ? -1 : model_pick(rq);
    eg = '0;
    ea = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea = addr_q[w];
    end
    checks++;
    if (bus.gnt !== eg || bus.rom_addr !== ea || bus.rom_en !== (w >= 0)) begin
      errors++;
      $display("FAIL grant cycle %0d: got gnt=%b addr=%h en=%b expected gnt=%b addr=%h en=%b",
               cyc, bus.gnt, bus.rom_addr, bus.rom_en, eg, ea, (w >= 0));
    end
    if (w >= 0) sbq.push_back('{due: cyc + LAT + 1, oh: eg, data: rom_fn(ea)});
    if (r) begin
      foreach (sbq[k]) if (sbq[k].due <= cyc) keep.push_back(sbq[k]);
      sbq = keep;
      exp_ovr = 1'b0;
      m_ptr = 0;
    end else begin
      if (fs && rq != '0) exp_ovr = 1'b1;
      if (fs)          m_ptr = 0;
      else if (w >= 0) m_ptr = (w + 1) % NREQ;
    end
    if (w >= 0) addr_q[w] = AW'($urandom);
    last_w = w;
    after_rst = r;
  endtask

  initial begin
    bus.req = '0;
    bus.req_addr = '0;
    for (int i = 0; i < NREQ; i++) addr_q[i] = AW'($urandom);
    repeat (2) @(posedge clk);
    after_rst = 1'b1;
    mon_en = 1'b1;

    // Single read from requester 2 at 0x0123.
    addr_q[2] = 16'h0123;
    step(0, 0, 4'b0100);
    repeat (5) step(0, 0, 4'b0000);

    // Pointer back to 0, then everyone requesting.
    step(0, 1, 4'b0000);
    repeat (8) step(0, 0, 4'b1111);
    repeat (4) step(0, 0, 4'b0000);

    repeat (4) step(0, 0, 4'b1010);
    repeat (3) step(0, 0, 4'b0010);
    repeat (4) step(0, 0, 4'b0000);

    // frame_start with requests pending; search must restart at 0.
    step(0, 0, 4'b0010);
    step(0, 1, 4'b1100);
    step(0, 0, 4'b1001);
    step(0, 0, 4'b1000);
    repeat (4) step(0, 0, 4'b0000);

    // Reset one cycle after a grant, and grants suppressed during reset.
    step(0, 0, 4'b0010);
    step(0, 0, 4'b0100);
    step(1, 0, 4'b1111);
    step(1, 0, 4'b0000);
    repeat (5) step(0, 0, 4'b0000);

    // Random traffic: requests held until granted, optional back-to-back reuse.
    cur_req = '0;
    for (int n = 0; n < 600; n++) begin
      logic r, fs;
      for (int i = 0; i < NREQ; i++) begin
        if (cur_req[i] && last_w == i) cur_req[i] = ($urandom_range(0, 1) == 1);
        else if (!cur_req[i])          cur_req[i] = ($urandom_range(0, 2) == 0);
      end
      r  = ($urandom_range(0, 149) == 0);
      fs = ($urandom_range(0, 39) == 0);
      step(r, fs, cur_req);
    end

    repeat (LAT + 3) step(0, 0, 4'b0000);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0", sbq.size());
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
